// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and width helpers for the PC generator and BTB
package pc_pkg;

  // 2-bit direction counter encoding; bit 1 is the taken prediction
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // sequential fetch step in bytes
  localparam int PC_INC = 4;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int tag_w(input int addr_w, input int depth);
    return addr_w - $clog2(depth) - 2;
  endfunction

  // widths for the default configuration (32-bit PC, 16-entry BTB)
  localparam int IDX_W = idx_w(16);
  localparam int TAG_W = tag_w(32, 16);

endpackage

// File: rtl/pc_btb.sv
// rtl/pc_btb.sv - direct-mapped branch target buffer with 2-bit counters
// Ports:
//   clk, rst              clock, async active-high reset (clears valid bits)
//   lookup_word           word address (pc[ADDR_W-1:2]) being fetched
//   lookup_taken          entry hits and its counter predicts taken
//   lookup_target         stored target, word address
//   upd_valid/upd_word/upd_target_word/upd_taken  resolved-branch training port
module pc_btb
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] lookup_word,
  output logic              lookup_taken,
  output logic [ADDR_W-3:0] lookup_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-3:0] upd_word,
  input  logic [ADDR_W-3:0] upd_target_word,
  input  logic              upd_taken
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int BIDX_W = idx_w(BTB_DEPTH);
  localparam int BTAG_W = tag_w(ADDR_W, BTB_DEPTH);

  logic              valid_q [BTB_DEPTH];
  logic [BTAG_W-1:0] tag_q   [BTB_DEPTH];
  logic [WORD_W-1:0] tgt_q   [BTB_DEPTH];
  logic [1:0]        ctr_q   [BTB_DEPTH];

  logic [BIDX_W-1:0] lk_idx;
  logic [BTAG_W-1:0] lk_tag;
  logic [BIDX_W-1:0] up_idx;
  logic [BTAG_W-1:0] up_tag;
  logic              lk_hit;
  logic              up_hit;
  logic [1:0]        ctr_next;

  assign lk_idx = lookup_word[BIDX_W-1:0];
  assign lk_tag = lookup_word[WORD_W-1:BIDX_W];
  assign up_idx = upd_word[BIDX_W-1:0];
  assign up_tag = upd_word[WORD_W-1:BIDX_W];

  // lookup reads the registered array, so a same-edge update is seen next cycle
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lookup_taken  = lk_hit && ctr_q[lk_idx][1];
  assign lookup_target = tgt_q[lk_idx];

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    ctr_next = ctr_q[up_idx];
    if (upd_taken) begin
      if (ctr_q[up_idx] != CTR_ST) ctr_next = ctr_q[up_idx] + 2'd1;
    end else begin
      if (ctr_q[up_idx] != CTR_SNT) ctr_next = ctr_q[up_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_SNT;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next;
        if (upd_taken) tgt_q[up_idx] <= upd_target_word;
      end else if (upd_taken) begin
        // allocation evicts whatever occupied the slot
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= upd_target_word;
        ctr_q[up_idx]   <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/pc_gen_btb.sv
// rtl/pc_gen_btb.sv - fetch PC register and next-PC selection with BTB prediction
// Ports:
//   clk, rst                   clock, async active-high reset
//   stall                      ctrl stall vector; bit 0 holds the PC
//   redirect_valid/_addr       EX redirect (addr bits [1:0] ignored)
//   upd_valid/_pc/_target/_taken  resolved-branch BTB training
//   pc                         current fetch PC (word aligned)
//   pred_taken, pred_target    combinational prediction for pc
module pc_gen_btb
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BTB_DEPTH = 16,
  parameter int                STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               upd_valid,
  input  logic [ADDR_W-1:0]  upd_pc,
  input  logic [ADDR_W-1:0]  upd_target,
  input  logic               upd_taken,
  output logic [ADDR_W-1:0]  pc,
  output logic               pred_taken,
  output logic [ADDR_W-1:0]  pred_target
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] redir_aligned;
  logic [ADDR_W-3:0] btb_target;
  logic              unused_bits;

  // low address bits and the upper stall bits carry no meaning here
  assign unused_bits = ^{stall, redirect_addr[1:0], upd_pc[1:0], upd_target[1:0]};

  pc_btb #(
    .ADDR_W    (ADDR_W),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk             (clk),
    .rst             (rst),
    .lookup_word     (pc_q[ADDR_W-1:2]),
    .lookup_taken    (pred_taken),
    .lookup_target   (btb_target),
    .upd_valid       (upd_valid),
    .upd_word        (upd_pc[ADDR_W-1:2]),
    .upd_target_word (upd_target[ADDR_W-1:2]),
    .upd_taken       (upd_taken)
  );

  assign pc            = pc_q;
  assign redir_aligned = {redirect_addr[ADDR_W-1:2], 2'b00};
  assign pred_target   = pred_taken ? {btb_target, 2'b00} : pc_q + ADDR_W'(PC_INC);

  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (stall[0]) begin
      // park the redirect so it is not lost; a newer one replaces it
      if (redirect_valid) begin
        pend_d      = 1'b1;
        pend_addr_d = redir_aligned;
      end
    end else if (redirect_valid) begin
      pc_d   = redir_aligned;
      pend_d = 1'b0;
    end else if (pend_q) begin
      pc_d   = pend_addr_q;
      pend_d = 1'b0;
    end else begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_gen_btb.sv
// tb/tb_pc_gen_btb.sv - directed self-checking bench for pc_gen_btb
module tb_pc_gen_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  int errors = 0;
  int checks = 0;

  pc_gen_btb dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic train(input logic [31:0] p, input logic [31:0] t, input logic tk);
    upd_valid  = 1'b1;
    upd_pc     = p;
    upd_target = t;
    upd_taken  = tk;
    step();
    upd_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = '0; redirect_valid = 1'b0; redirect_addr = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    #3;
    check("reset_pc", pc, 32'h0);
    check("reset_pred_taken", {31'b0, pred_taken}, 32'h0);
    check("reset_pred_target", pred_target, 32'h4);
    step(); step();
    rst = 1'b0;

    // sequential fetch, then hold under stall
    step(); check("seq_1", pc, 32'h4);
    step(); check("seq_2", pc, 32'h8);
    step(); check("seq_3", pc, 32'hC);
    stall = 6'b000001;
    step(); step(); check("stall_hold", pc, 32'hC);

    // redirect during stall is parked and applied on release
    redirect_to(32'h103);
    check("pend_hold_1", pc, 32'hC);
    step(); check("pend_hold_2", pc, 32'hC);
    stall = '0;
    step(); check("pend_apply", pc, 32'h100);
    step(); check("pend_after", pc, 32'h104);

    // newer redirect in the same stall replaces the older one
    stall = 6'b000001;
    redirect_to(32'h300);
    redirect_to(32'h400);
    stall = '0;
    step(); check("pend_overwrite", pc, 32'h400);

    // upper stall bits do not freeze the PC
    stall = 6'b111110;
    step(); check("upper_stall", pc, 32'h404);
    stall = '0;

    // allocate 0x20 -> 0x80 and predict it
    train(32'h20, 32'h80, 1'b1);
    redirect_to(32'h20);
    check("btb_hit_pc", pc, 32'h20);
    check("btb_hit_taken", {31'b0, pred_taken}, 32'h1);
    check("btb_hit_target", pred_target, 32'h80);
    step(); check("btb_follow", pc, 32'h80);

    // two not-taken updates: 10 -> 01 -> 00
    train(32'h20, 32'h0, 1'b0);
    train(32'h20, 32'h0, 1'b0);
    redirect_to(32'h20);
    check("btb_nt_taken", {31'b0, pred_taken}, 32'h0);
    check("btb_nt_target", pred_target, 32'h24);
    step(); check("btb_nt_next", pc, 32'h24);

    // retrain to weak taken (00 -> 01 -> 10), then alias 0x60 on same index
    train(32'h20, 32'h80, 1'b1);
    redirect_to(32'h20);
    check("btb_wnt_taken", {31'b0, pred_taken}, 32'h0);
    train(32'h20, 32'h80, 1'b1);
    redirect_to(32'h60);
    check("alias_miss_taken", {31'b0, pred_taken}, 32'h0);
    step(); check("alias_miss_next", pc, 32'h64);
    train(32'h60, 32'h500, 1'b0);
    redirect_to(32'h20);
    check("alias_keep_taken", {31'b0, pred_taken}, 32'h1);
    check("alias_keep_target", pred_target, 32'h80);

    // redirect beats a taken prediction
    redirect_to(32'h200);
    check("redirect_wins", pc, 32'h200);

    // wrap at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    check("wrap_pred", {31'b0, pred_taken}, 32'h0);
    step(); check("wrap_next", pc, 32'h0);

    // same-cycle update/lookup: old contents now, new contents next cycle
    redirect_to(32'h30);
    stall = 6'b000001;
    upd_valid = 1'b1; upd_pc = 32'h30; upd_target = 32'h90; upd_taken = 1'b1;
    check("same_cycle_old", {31'b0, pred_taken}, 32'h0);
    step();
    upd_valid = 1'b0;
    check("same_cycle_new", {31'b0, pred_taken}, 32'h1);
    check("same_cycle_tgt", pred_target, 32'h90);
    stall = '0;
    step(); check("same_cycle_follow", pc, 32'h90);

    // asynchronous reset mid-cycle
    redirect_to(32'h40);
    check("pre_reset_pc", pc, 32'h40);
    #2 rst = 1'b1;
    #1;
    check("async_reset_pc", pc, 32'h0);
    check("async_reset_pred", {31'b0, pred_taken}, 32'h0);
    step();
    rst = 1'b0;
    redirect_to(32'h20);
    check("reset_clears_btb", {31'b0, pred_taken}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
